// File: rtl/alu_arb.sv
// Two-requester arbiter in front of a shared combinational ALU: registers operands, waits SETTLE_CYC cycles, returns the result.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module alu_arb #(
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [2:0]  req0_sel,
    input  logic [9:0]  req0_a,
    input  logic [9:0]  req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [2:0]  req1_sel,
    input  logic [9:0]  req1_a,
    input  logic [9:0]  req1_b,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [19:0] rsp0_y,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [19:0] rsp1_y,
    output logic [9:0]  alu_a,
    output logic [9:0]  alu_b,
    output logic [2:0]  alu_sel,
    input  logic [19:0] alu_y,
    output logic        busy,
    output logic        grant
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        ptr_q, ptr_d;
    logic        grant_q, grant_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [9:0]  alu_a_q, alu_a_d;
    logic [9:0]  alu_b_q, alu_b_d;
    logic [2:0]  alu_sel_q, alu_sel_d;
    logic [19:0] result_q, result_d;

    logic        win_valid;
    logic        win_idx;
    logic        accept;

    // Winner selection; a lone requester wins regardless of the pointer.
    always_comb begin
        win_valid = req0_valid | req1_valid;
`ifdef ALU_ARB_FIXED_PRIO_EN
        win_idx = ~req0_valid;
`else
        if (req0_valid && req1_valid) begin
            win_idx = ptr_q;
        end else begin
            win_idx = req1_valid;
        end
`endif
    end

    assign accept = (state_q == IDLE) && win_valid;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        cnt_d     = cnt_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_sel_d = alu_sel_q;
        result_d  = result_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    alu_sel_d = win_idx ? req1_sel : req0_sel;
                    alu_a_d   = win_idx ? req1_a   : req0_a;
                    alu_b_d   = win_idx ? req1_b   : req0_b;
                    grant_d   = win_idx;
                    ptr_d     = ~win_idx;
                    cnt_d     = 4'(SETTLE_CYC - 1);
                    state_d   = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == 4'd0) begin
                    result_d = alu_y;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                // Only the granted requester's rsp_ready completes the response.
                if (grant_q ? rsp1_ready : rsp0_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= 1'b0;
            grant_q   <= 1'b0;
            cnt_q     <= 4'd0;
            alu_a_q   <= 10'd0;
            alu_b_q   <= 10'd0;
            alu_sel_q <= 3'd0;
            result_q  <= 20'd0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            cnt_q     <= cnt_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_sel_q <= alu_sel_d;
            result_q  <= result_d;
        end
    end

    // Ready is masked during reset so no handshake appears to complete.
    assign req0_ready = accept && !rst && (win_idx == 1'b0);
    assign req1_ready = accept && !rst && (win_idx == 1'b1);
    assign rsp0_valid = (state_q == RESP) && !grant_q;
    assign rsp1_valid = (state_q == RESP) && grant_q;
    assign rsp0_y     = result_q;
    assign rsp1_y     = result_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_sel    = alu_sel_q;
    assign busy       = (state_q != IDLE);
    assign grant      = grant_q;

endmodule

// File: tb/tb_alu_arb.sv
// Self-checking bench for alu_arb: bench-side ALU model, scoreboard of expected results, scenario tasks.
module tb_alu_arb;

    logic        clk;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [2:0]  req0_sel, req1_sel;
    logic [9:0]  req0_a, req0_b, req1_a, req1_b;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready, rsp1_ready;
    logic [19:0] rsp0_y, rsp1_y;
    logic [9:0]  alu_a, alu_b;
    logic [2:0]  alu_sel;
    logic [19:0] alu_y;
    logic        busy, grant;

    int n_checks = 0;
    int n_pass   = 0;

    logic [19:0] exp_q[$];
    bit          exp_id_q[$];

    alu_arb #(.SETTLE_CYC(2)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sel(req0_sel),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sel(req1_sel),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_y(rsp0_y),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_y(rsp1_y),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_y(alu_y),
        .busy(busy), .grant(grant)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] alu_fn(input logic [2:0] s, input logic [9:0] a, input logic [9:0] b);
        logic [19:0] ea, eb;
        ea = {10'd0, a};
        eb = {10'd0, b};
        case (s)
            3'd0:    alu_fn = ea + eb;
            3'd1:    alu_fn = ea - eb;
            3'd2:    alu_fn = ea * eb;
            3'd3:    alu_fn = ea & eb;
            3'd4:    alu_fn = ea | eb;
            3'd5:    alu_fn = ea ^ eb;
            3'd6:    alu_fn = {a, b};
            default: alu_fn = ea;
        endcase
    endfunction

    assign alu_y = alu_fn(alu_sel, alu_a, alu_b);

    // scoreboard: push on accepted request, pop on consumed response
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            exp_id_q.delete();
        end else begin
            n_checks++;
            if (req0_ready && req1_ready) $display("FAIL both_ready got=11 want=one-hot");
            else n_pass++;
            if (req0_valid && req0_ready) begin
                exp_q.push_back(alu_fn(req0_sel, req0_a, req0_b));
                exp_id_q.push_back(1'b0);
            end
            if (req1_valid && req1_ready) begin
                exp_q.push_back(alu_fn(req1_sel, req1_a, req1_b));
                exp_id_q.push_back(1'b1);
            end
            if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL sb_spurious got rsp0_valid=%0b rsp1_valid=%0b want no response", rsp0_valid, rsp1_valid);
                end else begin
                    logic [19:0] e;
                    bit          eid;
                    logic [19:0] y;
                    e   = exp_q.pop_front();
                    eid = exp_id_q.pop_front();
                    y   = rsp1_valid ? rsp1_y : rsp0_y;
                    if (rsp1_valid !== eid || y !== e)
                        $display("FAIL sb_result got id=%0b y=%0d want id=%0b y=%0d", rsp1_valid, y, eid, e);
                    else n_pass++;
                end
            end
        end
    end

    // driver tasks
    task automatic idle_inputs();
        req0_valid = 0; req1_valid = 0;
        req0_sel = 0; req0_a = 0; req0_b = 0;
        req1_sel = 0; req1_a = 0; req1_b = 0;
        rsp0_ready = 1; rsp1_ready = 1;
    endtask

    task automatic issue(input bit idx, input logic [2:0] sel, input logic [9:0] a,
                         input logic [9:0] b, output bit ok);
        @(posedge clk); #1;
        if (idx) begin req1_valid = 1; req1_sel = sel; req1_a = a; req1_b = b; end
        else     begin req0_valid = 1; req0_sel = sel; req0_a = a; req0_b = b; end
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (idx ? req1_ready : req0_ready) ok = 1;
        end
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
    endtask

    task automatic wait_idle(input bit rand_ready);
        bit done;
        done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(posedge clk); #1;
            if (rand_ready) begin
                rsp0_ready = 1'($urandom_range(0, 1));
                rsp1_ready = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            if (!busy) done = 1;
        end
        rsp0_ready = 1; rsp1_ready = 1;
        n_checks++;
        if (!done) $display("FAIL wait_idle got busy=%0b want 0 within 100 cycles", busy);
        else n_pass++;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        req0_valid = 1; req0_a = 10'd3; req0_b = 10'd4;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, grant} !== 6'b0)
            $display("FAIL reset_ctrl got rdy=%b%b vld=%b%b busy=%b grant=%b want all 0",
                     req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, grant);
        else n_pass++;
        n_checks++;
        if ({alu_sel, alu_a, alu_b} !== 23'd0 || rsp0_y !== 20'd0)
            $display("FAIL reset_data got sel=%0d a=%0d b=%0d y=%0d want 0", alu_sel, alu_a, alu_b, rsp0_y);
        else n_pass++;
        @(posedge clk); #1;
        rst = 0; req0_valid = 0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL reset_no_accept got busy=%0b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_basic_latency();
        @(posedge clk); #1;
        req0_valid = 1; req0_sel = 3'd0; req0_a = 10'd5; req0_b = 10'd7;
        @(negedge clk);
        n_checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0)
            $display("FAIL basic_ready got r0=%0b r1=%0b want 1 0", req0_ready, req1_ready);
        else n_pass++;
        @(posedge clk); #1;
        req0_valid = 0;
        for (int k = 1; k <= 3; k++) begin
            if (k > 1) @(posedge clk);
            @(negedge clk);
            n_checks++;
            if (rsp0_valid !== (k == 3) || rsp1_valid !== 1'b0 || busy !== 1'b1)
                $display("FAIL basic_latency cyc=T+%0d got rsp0_valid=%0b rsp1_valid=%0b busy=%0b want %0b 0 1",
                         k, rsp0_valid, rsp1_valid, busy, (k == 3));
            else n_pass++;
        end
        n_checks++;
        if (rsp0_y !== 20'd12) $display("FAIL basic_y got %0d want 12", rsp0_y);
        else n_pass++;
        wait_idle(0);
    endtask

    task automatic test_mul();
        bit ok;
        bit seen;
        issue(1'b1, 3'd2, 10'd1023, 10'd1023, ok);
        @(negedge clk);
        n_checks++;
        if (!ok || alu_sel !== 3'd2 || alu_a !== 10'd1023 || alu_b !== 10'd1023 || grant !== 1'b1)
            $display("FAIL mul_latch got ok=%0b sel=%0d a=%0d b=%0d grant=%0b want 1 2 1023 1023 1",
                     ok, alu_sel, alu_a, alu_b, grant);
        else n_pass++;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (rsp1_valid) seen = 1;
            else @(negedge clk);
        end
        n_checks++;
        if (!seen || rsp1_y !== 20'd1046529 || rsp0_valid !== 1'b0)
            $display("FAIL mul_result got seen=%0b y=%0d rsp0_valid=%0b want 1 1046529 0", seen, rsp1_y, rsp0_valid);
        else n_pass++;
        wait_idle(0);
    endtask

    task automatic test_round_robin();
        bit order[4];
        int n;
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        req0_valid = 1; req0_sel = 3'd3; req0_a = 10'h2F0; req0_b = 10'h0FF;
        req1_valid = 1; req1_sel = 3'd5; req1_a = 10'h155; req1_b = 10'h0AA;
        n = 0;
        for (int i = 0; i < 60 && n < 4; i++) begin
            @(negedge clk);
            if (req0_ready) begin order[n] = 1'b0; n++; end
            else if (req1_ready) begin order[n] = 1'b1; n++; end
        end
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        n_checks++;
        if (n != 4) $display("FAIL rr_count got %0d want 4", n);
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            bit want;
`ifdef ALU_ARB_FIXED_PRIO_EN
            want = 1'b0;
`else
            want = 1'(k % 2);
`endif
            n_checks++;
            if (order[k] !== want) $display("FAIL rr_order idx=%0d got %0b want %0b", k, order[k], want);
            else n_pass++;
        end
        wait_idle(0);
    endtask

    task automatic test_resp_hold();
        bit ok;
        bit seen;
        logic [19:0] held;
        rsp0_ready = 0;
        issue(1'b0, 3'd1, 10'd3, 10'd9, ok);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (rsp0_valid) seen = 1;
        end
        held = rsp0_y;
        n_checks++;
        if (!ok || !seen || held !== 20'hFFFFA)
            $display("FAIL hold_enter got ok=%0b seen=%0b y=%h want 1 1 fffffa", ok, seen, held);
        else n_pass++;
        @(posedge clk); #1;
        req0_valid = 1; req1_valid = 1; rsp1_ready = 1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++;
            if (rsp0_valid !== 1'b1 || rsp0_y !== held || req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b1)
                $display("FAIL hold_stall cyc=%0d got vld=%0b y=%h r0=%0b r1=%0b busy=%0b want 1 %h 0 0 1",
                         k, rsp0_valid, rsp0_y, req0_ready, req1_ready, busy, held);
            else n_pass++;
        end
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0; rsp0_ready = 1;
        wait_idle(0);
    endtask

    task automatic test_reset_abort();
        bit ok;
        bit spurious;
        issue(1'b1, 3'd5, 10'h3A5, 10'h0F0, ok);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        n_checks++;
        if (!ok || busy !== 1'b0 || {alu_sel, alu_a, alu_b} !== 23'd0 || rsp1_valid !== 1'b0)
            $display("FAIL abort_state got ok=%0b busy=%0b sel=%0d a=%0d b=%0d rsp1_valid=%0b want 1 0 0 0 0 0",
                     ok, busy, alu_sel, alu_a, alu_b, rsp1_valid);
        else n_pass++;
        spurious = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp0_valid || rsp1_valid) spurious = 1;
        end
        n_checks++;
        if (spurious) $display("FAIL abort_no_rsp got rsp_valid=1 want 0 for aborted op");
        else n_pass++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 16; it++) begin
            int  mask;
            bit  ok;
            mask = $urandom_range(1, 3);
            @(posedge clk); #1;
            req0_sel = 3'($urandom_range(0, 7)); req0_a = 10'($urandom_range(0, 1023)); req0_b = 10'($urandom_range(0, 1023));
            req1_sel = 3'($urandom_range(0, 7)); req1_a = 10'($urandom_range(0, 1023)); req1_b = 10'($urandom_range(0, 1023));
            req0_valid = mask[0]; req1_valid = mask[1];
            ok = 0;
            for (int i = 0; i < 50 && !ok; i++) begin
                @(negedge clk);
                if (req0_ready || req1_ready) ok = 1;
            end
            @(posedge clk); #1;
            req0_valid = 0; req1_valid = 0;
            n_checks++;
            if (!ok) $display("FAIL rand_accept iter=%0d got no ready want accept", it);
            else n_pass++;
            wait_idle(1);
        end
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_basic_latency();
        test_mul();
        test_round_robin();
        test_resp_hold();
        test_reset_abort();
        test_random();
        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL sb_drain got %0d pending want 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
